// File: rtl/axil_to_axi_bridge.sv
// AXI-Lite slave to AXI4 master bridge with 1-entry request buffers, outstanding limits and fixed ID.
// Optional response watchdog enabled by defining AXIL_TO_AXI_TIMEOUT_EN.
module axil_to_axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter logic [AXI_ID_WIDTH-1:0] MST_ID = '0,
  parameter int unsigned MAX_WR_TXNS    = 4,
  parameter int unsigned MAX_RD_TXNS    = 4,
  parameter logic [3:0]  AW_CACHE       = 4'b0000,
  parameter logic [3:0]  AR_CACHE       = 4'b0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AXI_ADDR_WIDTH-1:0]   slv_aw_awaddr_i,
  input  logic [2:0]                  slv_aw_awprot_i,
  input  logic                        slv_aw_awvalid_i,
  output logic                        slv_aw_awready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   slv_w_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_wstrb_i,
  input  logic                        slv_w_wvalid_i,
  output logic                        slv_w_wready_o,
  output logic [1:0]                  slv_b_bresp_o,
  output logic                        slv_b_bvalid_o,
  input  logic                        slv_b_bready_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   slv_ar_araddr_i,
  input  logic [2:0]                  slv_ar_arprot_i,
  input  logic                        slv_ar_arvalid_i,
  output logic                        slv_ar_arready_o,
  output logic [AXI_DATA_WIDTH-1:0]   slv_r_rdata_o,
  output logic [1:0]                  slv_r_rresp_o,
  output logic                        slv_r_rvalid_o,
  input  logic                        slv_r_rready_i,
  output logic [AXI_ID_WIDTH-1:0]     mst_aw_awid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_awaddr_o,
  output logic [7:0]                  mst_aw_awlen_o,
  output logic [2:0]                  mst_aw_awsize_o,
  output logic [1:0]                  mst_aw_awburst_o,
  output logic                        mst_aw_awlock_o,
  output logic [3:0]                  mst_aw_awcache_o,
  output logic [2:0]                  mst_aw_awprot_o,
  output logic [3:0]                  mst_aw_awregion_o,
  output logic [3:0]                  mst_aw_awqos_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_aw_awuser_o,
  output logic                        mst_aw_awvalid_o,
  input  logic                        mst_aw_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]   mst_w_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mst_w_wstrb_o,
  output logic                        mst_w_wlast_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_w_wuser_o,
  output logic                        mst_w_wvalid_o,
  input  logic                        mst_w_wready_i,
  input  logic [AXI_ID_WIDTH-1:0]     mst_b_bid_i,
  input  logic [1:0]                  mst_b_bresp_i,
  input  logic [AXI_USER_WIDTH-1:0]   mst_b_buser_i,
  input  logic                        mst_b_bvalid_i,
  output logic                        mst_b_bready_o,
  output logic [AXI_ID_WIDTH-1:0]     mst_ar_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mst_ar_araddr_o,
  output logic [7:0]                  mst_ar_arlen_o,
  output logic [2:0]                  mst_ar_arsize_o,
  output logic [1:0]                  mst_ar_arburst_o,
  output logic                        mst_ar_arlock_o,
  output logic [3:0]                  mst_ar_arcache_o,
  output logic [2:0]                  mst_ar_arprot_o,
  output logic [3:0]                  mst_ar_arregion_o,
  output logic [3:0]                  mst_ar_arqos_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_ar_aruser_o,
  output logic                        mst_ar_arvalid_o,
  input  logic                        mst_ar_arready_i,
  input  logic [AXI_ID_WIDTH-1:0]     mst_r_rid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mst_r_rdata_i,
  input  logic [1:0]                  mst_r_rresp_i,
  input  logic                        mst_r_rlast_i,
  input  logic [AXI_USER_WIDTH-1:0]   mst_r_ruser_i,
  input  logic                        mst_r_rvalid_i,
  output logic                        mst_r_rready_o,
  output logic                        timeout_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(STRB_W));
  localparam logic [7:0] MAX_WR = 8'(MAX_WR_TXNS);
  localparam logic [7:0] MAX_RD = 8'(MAX_RD_TXNS);

  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] res;
    case ({inc, dec && (cnt != 8'd0)})
      2'b10:   res = cnt + 8'd1;
      2'b01:   res = cnt - 8'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

  logic                      aw_vld_q, w_vld_q, ar_vld_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [2:0]                aw_prot_q, ar_prot_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic [7:0]                wr_cnt_q, w_cnt_q, rd_cnt_q;
  logic                      aw_hs_s, w_hs_s, ar_hs_s, b_dlv_s, r_dlv_s;
  logic                      b_pend_s, r_pend_s, b_drop_s, r_drop_s;
  logic                      unused_s;

  assign slv_aw_awready_o = !aw_vld_q;
  assign slv_w_wready_o   = !w_vld_q;
  assign slv_ar_arready_o = !ar_vld_q;

  assign mst_aw_awvalid_o = aw_vld_q && (wr_cnt_q < MAX_WR);
  assign mst_w_wvalid_o   = w_vld_q && (w_cnt_q < MAX_WR);
  assign mst_ar_arvalid_o = ar_vld_q && (rd_cnt_q < MAX_RD);

  assign aw_hs_s = mst_aw_awvalid_o && mst_aw_awready_i;
  assign w_hs_s  = mst_w_wvalid_o && mst_w_wready_i;
  assign ar_hs_s = mst_ar_arvalid_o && mst_ar_arready_i;
  assign b_dlv_s = slv_b_bvalid_o && slv_b_bready_i;
  assign r_dlv_s = slv_r_rvalid_o && slv_r_rready_i;

  assign mst_aw_awid_o     = MST_ID;
  assign mst_aw_awaddr_o   = aw_addr_q;
  assign mst_aw_awlen_o    = 8'd0;
  assign mst_aw_awsize_o   = BEAT_SIZE;
  assign mst_aw_awburst_o  = 2'b01;
  assign mst_aw_awlock_o   = 1'b0;
  assign mst_aw_awcache_o  = AW_CACHE;
  assign mst_aw_awprot_o   = aw_prot_q;
  assign mst_aw_awregion_o = 4'd0;
  assign mst_aw_awqos_o    = 4'd0;
  assign mst_aw_awuser_o   = '0;
  assign mst_w_wdata_o     = w_data_q;
  assign mst_w_wstrb_o     = w_strb_q;
  assign mst_w_wlast_o     = 1'b1;
  assign mst_w_wuser_o     = '0;
  assign mst_ar_arid_o     = MST_ID;
  assign mst_ar_araddr_o   = ar_addr_q;
  assign mst_ar_arlen_o    = 8'd0;
  assign mst_ar_arsize_o   = BEAT_SIZE;
  assign mst_ar_arburst_o  = 2'b01;
  assign mst_ar_arlock_o   = 1'b0;
  assign mst_ar_arcache_o  = AR_CACHE;
  assign mst_ar_arprot_o   = ar_prot_q;
  assign mst_ar_arregion_o = 4'd0;
  assign mst_ar_arqos_o    = 4'd0;
  assign mst_ar_aruser_o   = '0;

  assign unused_s = ^{mst_b_bid_i, mst_b_buser_i, mst_r_rid_i, mst_r_rlast_i, mst_r_ruser_i,
                      32'(TIMEOUT_CYCLES)};

  // Request buffers: load on slave handshake, clear on master handshake (never both at once).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_vld_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= 3'd0;
      w_vld_q   <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_prot_q <= 3'd0;
    end else begin
      if (slv_aw_awvalid_i && slv_aw_awready_o) begin
        aw_vld_q  <= 1'b1;
        aw_addr_q <= slv_aw_awaddr_i;
        aw_prot_q <= slv_aw_awprot_i;
      end else if (aw_hs_s) begin
        aw_vld_q <= 1'b0;
      end
      if (slv_w_wvalid_i && slv_w_wready_o) begin
        w_vld_q  <= 1'b1;
        w_data_q <= slv_w_wdata_i;
        w_strb_q <= slv_w_wstrb_i;
      end else if (w_hs_s) begin
        w_vld_q <= 1'b0;
      end
      if (slv_ar_arvalid_i && slv_ar_arready_o) begin
        ar_vld_q  <= 1'b1;
        ar_addr_q <= slv_ar_araddr_i;
        ar_prot_q <= slv_ar_arprot_i;
      end else if (ar_hs_s) begin
        ar_vld_q <= 1'b0;
      end
    end
  end

  // Outstanding counters; both write counters retire on the B delivered upstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= 8'd0;
      w_cnt_q  <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      wr_cnt_q <= cnt_next(wr_cnt_q, aw_hs_s, b_dlv_s);
      w_cnt_q  <= cnt_next(w_cnt_q, w_hs_s, b_dlv_s);
      rd_cnt_q <= cnt_next(rd_cnt_q, ar_hs_s, r_dlv_s);
    end
  end

`ifdef AXIL_TO_AXI_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] b_wd_q, r_wd_q;
  logic            b_pend_q, r_pend_q, timeout_q;
  logic [7:0]      b_credit_q, r_credit_q;
  logic            b_real_hs_s, r_real_hs_s;

  assign b_real_hs_s = mst_b_bvalid_i && mst_b_bready_o;
  assign r_real_hs_s = mst_r_rvalid_i && mst_r_rready_o;
  assign b_pend_s    = b_pend_q;
  assign r_pend_s    = r_pend_q;
  assign b_drop_s    = (b_credit_q != 8'd0) || (wr_cnt_q == 8'd0);
  assign r_drop_s    = (r_credit_q != 8'd0) || (rd_cnt_q == 8'd0);
  assign timeout_o   = timeout_q;

  // Watchdogs count from the issuing cycle, so an error appears TIMEOUT_CYCLES after issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_wd_q     <= '0;
      r_wd_q     <= '0;
      b_pend_q   <= 1'b0;
      r_pend_q   <= 1'b0;
      b_credit_q <= 8'd0;
      r_credit_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= (b_pend_q && slv_b_bready_i) || (r_pend_q && slv_r_rready_i);
      if (b_pend_q) begin
        if (slv_b_bready_i) begin
          b_pend_q   <= 1'b0;
          b_credit_q <= b_credit_q + 8'd1;
          b_wd_q     <= '0;
        end
      end else if (b_real_hs_s || ((wr_cnt_q == 8'd0) && !aw_hs_s)) begin
        b_wd_q <= '0;
        if (b_real_hs_s && (b_credit_q != 8'd0)) begin
          b_credit_q <= b_credit_q - 8'd1;
        end
      end else if (b_wd_q == WD_LAST) begin
        b_pend_q <= 1'b1;
        b_wd_q   <= '0;
      end else begin
        b_wd_q <= b_wd_q + 1'b1;
      end
      if (r_pend_q) begin
        if (slv_r_rready_i) begin
          r_pend_q   <= 1'b0;
          r_credit_q <= r_credit_q + 8'd1;
          r_wd_q     <= '0;
        end
      end else if (r_real_hs_s || ((rd_cnt_q == 8'd0) && !ar_hs_s)) begin
        r_wd_q <= '0;
        if (r_real_hs_s && (r_credit_q != 8'd0)) begin
          r_credit_q <= r_credit_q - 8'd1;
        end
      end else if (r_wd_q == WD_LAST) begin
        r_pend_q <= 1'b1;
        r_wd_q   <= '0;
      end else begin
        r_wd_q <= r_wd_q + 1'b1;
      end
    end
  end
`else
  assign b_pend_s  = 1'b0;
  assign r_pend_s  = 1'b0;
  assign b_drop_s  = (wr_cnt_q == 8'd0);
  assign r_drop_s  = (rd_cnt_q == 8'd0);
  assign timeout_o = 1'b0;
`endif

  // Response steering: synthesised error, silent drop, or combinational pass-through.
  always_comb begin
    slv_b_bvalid_o = 1'b0;
    slv_b_bresp_o  = mst_b_bresp_i;
    mst_b_bready_o = 1'b1;
    if (b_pend_s) begin
      slv_b_bvalid_o = 1'b1;
      slv_b_bresp_o  = 2'b10;
      mst_b_bready_o = 1'b0;
    end else if (b_drop_s) begin
      slv_b_bvalid_o = 1'b0;
      mst_b_bready_o = 1'b1;
    end else begin
      slv_b_bvalid_o = mst_b_bvalid_i;
      mst_b_bready_o = slv_b_bready_i;
    end
  end

  // Same steering for the read data channel.
  always_comb begin
    slv_r_rvalid_o = 1'b0;
    slv_r_rdata_o  = mst_r_rdata_i;
    slv_r_rresp_o  = mst_r_rresp_i;
    mst_r_rready_o = 1'b1;
    if (r_pend_s) begin
      slv_r_rvalid_o = 1'b1;
      slv_r_rdata_o  = '0;
      slv_r_rresp_o  = 2'b10;
      mst_r_rready_o = 1'b0;
    end else if (r_drop_s) begin
      slv_r_rvalid_o = 1'b0;
      mst_r_rready_o = 1'b1;
    end else begin
      slv_r_rvalid_o = mst_r_rvalid_i;
      mst_r_rready_o = slv_r_rready_i;
    end
  end

endmodule
